// File: rtl/ysyx_25020047_pkg.sv
// ============================================================================
// Module   : ysyx_25020047_pkg
// Purpose  : Shared state encodings and instruction-class constants for the
//            decoder and the execution control FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_25020047_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [31:0] IT_EBREAK  = 32'h0000_0004;
    localparam logic [31:0] IT_LW      = 32'h0000_0020;
    localparam logic [31:0] IT_LBU     = 32'h0000_0040;
    localparam logic [31:0] IT_SW      = 32'h0000_0080;
    localparam logic [31:0] IT_SB      = 32'h0000_0100;
    localparam logic [31:0] IT_BEQ     = 32'h0000_4000;
    localparam logic [31:0] IT_BNE     = 32'h0000_8000;
    localparam logic [31:0] IT_ILLEGAL = 32'hFFFF_FFFF;

    localparam logic [31:0] IS_LOAD   = IT_LW | IT_LBU;
    localparam logic [31:0] IS_STORE  = IT_SW | IT_SB;
    localparam logic [31:0] IS_BRANCH = IT_BEQ | IT_BNE;

    // Exactly one bit set; rejects both zero and the all-ones illegal marker.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_25020047_wait_timer.sv
// ============================================================================
// Module   : ysyx_25020047_wait_timer
// Purpose  : Handshake wait counter with clear, enable and expired flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25020047_wait_timer #(
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT);

    logic [TO_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && !expired) begin
            r_count <= r_count + TO_W'(1);
        end
    end

    assign expired = (r_count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/ysyx_25020047_exec_ctrl.sv
// ============================================================================
// Module   : ysyx_25020047_exec_ctrl
// Purpose  : Multi-cycle FETCH/DECODE/MEM/WB control FSM with halt, illegal
//            instruction and handshake-timeout handling.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25020047_exec_ctrl
    import ysyx_25020047_pkg::*;
#(
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_type,
    output logic        ifu_req,
    input  logic        ifu_rvalid,
    output logic        inst_latch,
    output logic        lsu_req,
    output logic        lsu_wen,
    input  logic        lsu_ack,
    output logic        reg_wen,
    output logic        pc_wen,
    output logic        halt,
    output logic        illegal,
    output logic        timeout,
    output logic [2:0]  state,
    output logic [31:0] retire_cnt
);

    state_t      r_state;
    logic        r_is_store;
    logic        r_no_rd;
    logic        r_halt;
    logic        r_illegal;
    logic        r_timeout;
    logic [31:0] r_retire;

    logic w_clr;
    logic w_wait_en;
    logic w_expired;

    // Clearing in DECODE/WB/IDLE makes the count start at 0 on entry to MEM/FETCH.
    assign w_clr     = (r_state == S_IDLE) || (r_state == S_DECODE) || (r_state == S_WB);
    assign w_wait_en = ((r_state == S_FETCH) && !ifu_rvalid) ||
                       ((r_state == S_MEM)   && !lsu_ack);

    ysyx_25020047_wait_timer #(
        .TO_W        (TO_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .en      (w_wait_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_is_store <= 1'b0;
            r_no_rd    <= 1'b0;
            r_halt     <= 1'b0;
            r_illegal  <= 1'b0;
            r_timeout  <= 1'b0;
            r_retire   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: begin
                    if (ifu_rvalid) begin
                        r_state <= S_DECODE;
                    end else if (w_expired) begin
                        r_state   <= S_ERR;
                        r_timeout <= 1'b1;
                    end
                end
                S_DECODE: begin
                    r_is_store <= (inst_type & IS_STORE) != 32'd0;
                    r_no_rd    <= (inst_type & (IS_STORE | IS_BRANCH)) != 32'd0;
                    if (inst_type == IT_EBREAK) begin
                        r_state  <= S_HALT;
                        r_halt   <= 1'b1;
                        r_retire <= r_retire + 32'd1;
                    end else if (!is_onehot(inst_type)) begin
                        r_state   <= S_ERR;
                        r_illegal <= 1'b1;
                    end else if ((inst_type & (IS_LOAD | IS_STORE)) != 32'd0) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    // An ack in the expiry cycle still completes the access.
                    if (lsu_ack) begin
                        r_state <= S_WB;
                    end else if (w_expired) begin
                        r_state   <= S_ERR;
                        r_timeout <= 1'b1;
                    end
                end
                S_WB: begin
                    r_state  <= S_FETCH;
                    r_retire <= r_retire + 32'd1;
                end
                S_HALT, S_ERR: r_state <= r_state;
                default: r_state <= S_ERR;
            endcase
        end
    end

    assign ifu_req    = (r_state == S_FETCH);
    assign inst_latch = (r_state == S_FETCH) && ifu_rvalid;
    assign lsu_req    = (r_state == S_MEM);
    assign lsu_wen    = (r_state == S_MEM) && r_is_store;
    assign reg_wen    = (r_state == S_WB) && !r_no_rd;
    assign pc_wen     = (r_state == S_WB);
    assign halt       = r_halt;
    assign illegal    = r_illegal;
    assign timeout    = r_timeout;
    assign state      = r_state;
    assign retire_cnt = r_retire;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25020047_exec_ctrl.sv
// ============================================================================
// Module   : tb_ysyx_25020047_exec_ctrl
// Purpose  : Scoreboard bench for the execution control FSM with a
//            class-level reference model and randomized handshake timing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_25020047_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_type = 32'd0;
    logic        ifu_rvalid = 1'b0;
    logic        lsu_ack = 1'b0;
    logic        ifu_req, inst_latch, lsu_req, lsu_wen, reg_wen, pc_wen;
    logic        halt, illegal, timeout;
    logic [2:0]  state;
    logic [31:0] retire_cnt;

    ysyx_25020047_exec_ctrl #(.TO_W(8), .MEM_TIMEOUT(255)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_type  (inst_type),
        .ifu_req    (ifu_req),
        .ifu_rvalid (ifu_rvalid),
        .inst_latch (inst_latch),
        .lsu_req    (lsu_req),
        .lsu_wen    (lsu_wen),
        .lsu_ack    (lsu_ack),
        .reg_wen    (reg_wen),
        .pc_wen     (pc_wen),
        .halt       (halt),
        .illegal    (illegal),
        .timeout    (timeout),
        .state      (state),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          mem;
        bit          store;
        bit          rd;
        int          mem_cycles;
        logic [31:0] retire_before;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_retired = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: instruction behaviour derived from its class alone.
    function automatic exp_t model(input logic [31:0] it, input int mw);
        exp_t e;
        e.store         = (it == 32'h80) || (it == 32'h100);
        e.mem           = (it == 32'h20) || (it == 32'h40) || e.store;
        e.rd            = !(e.store || it == 32'h4000 || it == 32'h8000);
        e.mem_cycles    = mw + 1;
        e.retire_before = model_retired;
        return e;
    endfunction

    // Monitor: pops one expectation per retirement, checks LSU phase on ack.
    int mem_run = 0;
    bit saw_mem = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            mem_run = 0;
            saw_mem = 1'b0;
        end else begin
            if (lsu_req) begin
                mem_run++;
                saw_mem = 1'b1;
                if (lsu_ack) begin
                    if (q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL lsu_unexpected: ack seen with empty scoreboard");
                    end else begin
                        check("lsu_wen", {31'd0, lsu_wen}, {31'd0, q[0].store});
                        check("lsu_req_cycles", mem_run, q[0].mem_cycles);
                    end
                end
            end
            if (pc_wen) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wb_unexpected: pc_wen with empty scoreboard");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("wb_reg_wen", {31'd0, reg_wen}, {31'd0, e.rd});
                    check("wb_retire", retire_cnt, e.retire_before);
                    check("wb_mem_path", {31'd0, saw_mem}, {31'd0, e.mem});
                end
                mem_run = 0;
                saw_mem = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (!ifu_req && n < 20) begin
            tick();
            n++;
        end
        check("fetch_ready", {31'd0, ifu_req}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ifu_rvalid = 1'b0;
        lsu_ack = 1'b0;
        inst_type = 32'd0;
        tick();
        tick();
        check("rst_outputs", {23'd0, ifu_req, inst_latch, lsu_req, lsu_wen, reg_wen,
                              pc_wen, halt, illegal, timeout}, 32'd0);
        check("rst_state", state, 32'd0);
        check("rst_retire", retire_cnt, 32'd0);
        rst = 1'b1;
        model_retired = 32'd0;
        #1;
        check("idle_after_release", state, 32'd0);
        tick();
        check("fetch_after_idle", state, 32'd1);
    endtask

    task automatic fetch(input logic [31:0] it, input int fw);
        wait_fetch();
        inst_type = it;
        repeat (fw) tick();
        ifu_rvalid = 1'b1;
        #1;
        check("inst_latch", {31'd0, inst_latch}, 32'd1);
        tick();
        ifu_rvalid = 1'b0;
        check("decode", state, 32'd2);
    endtask

    task automatic run_inst(input logic [31:0] it, input int fw, input int mw);
        exp_t e;
        e = model(it, mw);
        q.push_back(e);
        fetch(it, fw);
        tick();
        if (e.mem) begin
            check("mem_entry", state, 32'd3);
            repeat (mw) tick();
            lsu_ack = 1'b1;
            tick();
            lsu_ack = 1'b0;
        end
        check("wb_state", state, 32'd4);
        tick();
        check("refetch", state, 32'd1);
        model_retired = model_retired + 32'd1;
    endtask

    task automatic run_term(input logic [31:0] it, input logic [2:0] exp_state,
                            input bit exp_halt, input bit exp_illegal, input int retire_inc);
        fetch(it, $urandom_range(0, 2));
        tick();
        check("term_state", state, {29'd0, exp_state});
        check("term_flags", {29'd0, halt, illegal, timeout}, {29'd0, exp_halt, exp_illegal, 1'b0});
        check("term_retire", retire_cnt, model_retired + retire_inc);
    endtask

    logic [31:0] classes [13] = '{32'h1, 32'h2, 32'h8, 32'h10, 32'h20, 32'h40, 32'h80,
                                  32'h100, 32'h200, 32'h4000, 32'h8000, 32'h10000, 32'h8000_0000};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        do_reset();

        run_inst(32'h1, 0, 0);
        check("addi_retire", retire_cnt, 32'd1);
        run_inst(32'h20, 1, 3);
        run_inst(32'h80, 0, 2);
        run_inst(32'h8000, 2, 0);
        for (int i = 0; i < 40; i++) begin
            run_inst(classes[$urandom_range(0, 12)], $urandom_range(0, 3), $urandom_range(0, 4));
        end

        run_term(32'h4, 3'd5, 1'b1, 1'b0, 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("halt_quiet", {30'd0, ifu_req, pc_wen}, 32'd0);
        end

        do_reset();
        run_inst(32'h2, 0, 0);
        run_inst(32'h40, 1, 1);
        run_term(32'hFFFF_FFFF, 3'd6, 1'b0, 1'b1, 0);
        check("err_no_req", {31'd0, ifu_req}, 32'd0);

        do_reset();
        run_inst(32'h100, 0, 2);
        run_term(32'h3, 3'd6, 1'b0, 1'b1, 0);

        // LSU never acks: 256 MEM cycles (count 0..255) then ERR with timeout.
        do_reset();
        fetch(32'h20, 0);
        tick();
        check("to_mem_entry", state, 32'd3);
        n = 0;
        while (lsu_req && n < 400) begin
            n++;
            tick();
        end
        check("to_mem_cycles", n, 32'd256);
        check("to_state", state, 32'd6);
        check("to_flag", {31'd0, timeout}, 32'd1);
        check("to_retire", retire_cnt, 32'd0);

        // Ack in the final counted cycle must still win.
        do_reset();
        run_inst(32'h20, 0, 255);
        check("ack_at_limit_timeout", {31'd0, timeout}, 32'd0);
        check("ack_at_limit_retire", retire_cnt, 32'd1);

        // Asynchronous reset in the middle of a memory access.
        do_reset();
        run_inst(32'h1, 0, 0);
        fetch(32'h20, 0);
        tick();
        tick();
        check("mid_mem_req", {31'd0, lsu_req}, 32'd1);
        rst = 1'b0;
        #1;
        check("async_drop_req", {31'd0, lsu_req}, 32'd0);
        check("async_state", state, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        model_retired = 32'd0;
        #1;
        check("post_rst_idle", state, 32'd0);
        check("post_rst_retire", retire_cnt, 32'd0);
        tick();
        check("post_rst_fetch", state, 32'd1);
        run_inst(32'h8, 1, 0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
